// File: rtl/periph_bus_timer_pkg.sv
// Shared constants for the peripheral bus timer: register word offsets and TCON bit positions.
package periph_bus_timer_pkg;

    localparam logic [2:0] OFF_TH      = 3'd0;
    localparam logic [2:0] OFF_TL      = 3'd1;
    localparam logic [2:0] OFF_TCON    = 3'd2;
    localparam logic [2:0] OFF_LED     = 3'd3;
    localparam logic [2:0] OFF_SWITCH  = 3'd4;
    localparam logic [2:0] OFF_DIGI    = 3'd5;
    localparam logic [2:0] OFF_SYSTICK = 3'd6;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/periph_bus_timer_timer.sv
// Reloadable 32-bit timer: owns TH/TL/TCON, reload on overflow, sticky irq status.
// A CPU write to a register always overrides the timer's own update of it that cycle.
module periph_timer
    import periph_bus_timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        th_we_i,
    input  logic        tl_we_i,
    input  logic        tcon_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] th_o,
    output logic [31:0] tl_o,
    output logic [2:0]  tcon_o,
    output logic        irq_o
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic        overflow;

    always_comb begin
        th_d     = th_q;
        tl_d     = tl_q;
        tcon_d   = tcon_q;
        overflow = tcon_q[TCON_EN] && (tl_q == TL_MAX);

        if (tcon_q[TCON_EN]) begin
            tl_d = overflow ? th_q : tl_q + 32'd1;
        end
        if (overflow && tcon_q[TCON_IE]) begin
            tcon_d[TCON_IS] = 1'b1;
        end

        if (th_we_i) begin
            th_d = wdata_i;
        end
        // Overwriting TL cancels the overflow event, including its status set.
        if (tl_we_i) begin
            tl_d            = wdata_i;
            tcon_d[TCON_IS] = tcon_q[TCON_IS];
        end
        if (tcon_we_i) begin
            tcon_d = wdata_i[2:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q   <= 32'h0;
            tl_q   <= 32'h0;
            tcon_q <= 3'b000;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    assign th_o   = th_q;
    assign tl_o   = tl_q;
    assign tcon_o = tcon_q;
    assign irq_o  = tcon_q[TCON_IS] & tcon_q[TCON_IE];

endmodule

// File: rtl/periph_bus_timer.sv
// Memory-mapped timer/LED/7-seg/switch peripheral behind the core's MEM stage.
// Define PERIPH_SYSTICK_EN to add a free-running cycle counter at word offset 6.
module periph_bus_timer
    import periph_bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iMemAddr,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [31:0] iMemWriteData,
    output logic [31:0] oMemReadData,
    output logic        oInterrupt,
    input  logic [7:0]  iSwitch,
    output logic [7:0]  oLed,
    output logic [11:0] oDigi
);

    logic        hit;
    logic [2:0]  offset;
    logic        wr_en;
    logic        th_we, tl_we, tcon_we, led_we, digi_we;
    logic [31:0] th_val, tl_val;
    logic [2:0]  tcon_val;
    logic [31:0] rdata_sel;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [7:0]  sw_meta_q, sw_sync_q;
    logic        unused_addr_lsbs;

    assign hit              = (iMemAddr[31:5] == BASE_ADDR[31:5]);
    assign offset           = iMemAddr[4:2];
    assign wr_en            = iMemWrite & hit;
    assign unused_addr_lsbs = ^iMemAddr[1:0];

    assign th_we   = wr_en && (offset == OFF_TH);
    assign tl_we   = wr_en && (offset == OFF_TL);
    assign tcon_we = wr_en && (offset == OFF_TCON);
    assign led_we  = wr_en && (offset == OFF_LED);
    assign digi_we = wr_en && (offset == OFF_DIGI);

    periph_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .th_we_i   (th_we),
        .tl_we_i   (tl_we),
        .tcon_we_i (tcon_we),
        .wdata_i   (iMemWriteData),
        .th_o      (th_val),
        .tl_o      (tl_val),
        .tcon_o    (tcon_val),
        .irq_o     (oInterrupt)
    );

    assign led_d  = led_we  ? iMemWriteData[7:0]  : led_q;
    assign digi_d = digi_we ? iMemWriteData[11:0] : digi_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q     <= 8'h00;
            digi_q    <= 12'h000;
            sw_meta_q <= 8'h00;
            sw_sync_q <= 8'h00;
        end else begin
            led_q     <= led_d;
            digi_q    <= digi_d;
            sw_meta_q <= iSwitch;
            sw_sync_q <= sw_meta_q;
        end
    end

`ifdef PERIPH_SYSTICK_EN
    logic [31:0] systick_q, systick_d;

    assign systick_d = systick_q + 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            systick_q <= 32'h0;
        end else begin
            systick_q <= systick_d;
        end
    end
`endif

    always_comb begin
        rdata_sel = 32'h0;
        case (offset)
            OFF_TH:      rdata_sel = th_val;
            OFF_TL:      rdata_sel = tl_val;
            OFF_TCON:    rdata_sel = {29'h0, tcon_val};
            OFF_LED:     rdata_sel = {24'h0, led_q};
            OFF_SWITCH:  rdata_sel = {24'h0, sw_sync_q};
            OFF_DIGI:    rdata_sel = {20'h0, digi_q};
`ifdef PERIPH_SYSTICK_EN
            OFF_SYSTICK: rdata_sel = systick_q;
`endif
            default:     rdata_sel = 32'h0;
        endcase
    end

    assign oMemReadData = (iMemRead && hit) ? rdata_sel : 32'h0;
    assign oLed         = led_q;
    assign oDigi        = digi_q;

endmodule

// File: tb/tb_periph_bus_timer.sv
// Directed bench for periph_bus_timer: register table plus timer, reset, switch and systick sequences.
module tb_periph_bus_timer;

    logic        clk;
    logic        reset;
    logic [31:0] iMemAddr;
    logic        iMemRead;
    logic        iMemWrite;
    logic [31:0] iMemWriteData;
    logic [31:0] oMemReadData;
    logic        oInterrupt;
    logic [7:0]  iSwitch;
    logic [7:0]  oLed;
    logic [11:0] oDigi;

    int total_cnt;
    int pass_cnt;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_SW   = 32'h4000_0010;
    localparam logic [31:0] A_DIGI = 32'h4000_0014;
    localparam logic [31:0] A_TICK = 32'h4000_0018;
    localparam logic [31:0] A_RSVD = 32'h4000_001C;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[14];

    periph_bus_timer dut (
        .clk           (clk),
        .reset         (reset),
        .iMemAddr      (iMemAddr),
        .iMemRead      (iMemRead),
        .iMemWrite     (iMemWrite),
        .iMemWriteData (iMemWriteData),
        .oMemReadData  (oMemReadData),
        .oInterrupt    (oInterrupt),
        .iSwitch       (iSwitch),
        .oLed          (oLed),
        .oDigi         (oDigi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("check %-16s got %08h ok", name, act);
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        iMemAddr      = addr;
        iMemWriteData = data;
        iMemWrite     = 1'b1;
        cyc();
        iMemWrite     = 1'b0;
        iMemWriteData = 32'h0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        iMemAddr = addr;
        iMemRead = 1'b1;
        #1;
        check(name, oMemReadData, exp);
        iMemRead = 1'b0;
    endtask

    initial begin
        logic [31:0] tick0, tick1;
        total_cnt     = 0;
        pass_cnt      = 0;
        reset         = 1'b1;
        iMemAddr      = 32'h0;
        iMemRead      = 1'b0;
        iMemWrite     = 1'b0;
        iMemWriteData = 32'h0;
        iSwitch       = 8'h00;

        // we, re, addr, wdata, expected read data (sampled before the edge)
        vecs[0]  = '{1'b1, 1'b0, A_LED,  32'h0000_003C, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, A_LED,  32'h0,         32'h0000_003C};
        vecs[2]  = '{1'b1, 1'b0, A_DIGI, 32'hFFFF_FABC, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, A_DIGI, 32'h0,         32'h0000_0ABC};
        vecs[4]  = '{1'b1, 1'b0, A_TH,   32'h1234_5678, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, A_TH,   32'h0,         32'h1234_5678};
        vecs[6]  = '{1'b1, 1'b0, A_RSVD, 32'hFFFF_FFFF, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, A_RSVD, 32'h0,         32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h5000_000C, 32'h0000_00FF, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 32'h5000_000C, 32'h0,  32'h0};
        vecs[10] = '{1'b1, 1'b1, A_LED,  32'h0000_0055, 32'h0000_003C};
        vecs[11] = '{1'b0, 1'b1, 32'h4000_000F, 32'h0,  32'h0000_0055};
        vecs[12] = '{1'b0, 1'b0, A_LED,  32'h0,         32'h0};
        vecs[13] = '{1'b1, 1'b1, A_TCON, 32'hFFFF_FFF0, 32'h0};

        // Reset state
        #12;
        check("rst_irq",  {31'h0, oInterrupt}, 32'h0);
        check("rst_led",  {24'h0, oLed}, 32'h0);
        check("rst_digi", {20'h0, oDigi}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cyc();
        rd_check("rst_tl",   A_TL,   32'h0);
        rd_check("rst_tcon", A_TCON, 32'h0);

        // Register table
        for (int i = 0; i < 14; i++) begin
            iMemAddr      = vecs[i].addr;
            iMemWriteData = vecs[i].wdata;
            iMemWrite     = vecs[i].we;
            iMemRead      = vecs[i].re;
            #1;
            check($sformatf("vec%0d_rd", i), oMemReadData, vecs[i].exp_rd);
            cyc();
            iMemWrite = 1'b0;
            iMemRead  = 1'b0;
        end
        check("led_out",  {24'h0, oLed}, 32'h0000_0055);
        check("digi_out", {20'h0, oDigi}, 32'h0000_0ABC);
        rd_check("tcon_upper", A_TCON, 32'h0);

        // Asynchronous reset mid-count
        wr(A_TL, 32'h5);
        wr(A_TCON, 32'h3);
        cyc();
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_irq",  {31'h0, oInterrupt}, 32'h0);
        check("mid_rst_led",  {24'h0, oLed}, 32'h0);
        check("mid_rst_digi", {20'h0, oDigi}, 32'h0);
        cyc();
        @(negedge clk);
        reset = 1'b0;
        cyc();
        rd_check("mid_rst_tl", A_TL, 32'h0);
        cyc();
        rd_check("mid_rst_tl2", A_TL, 32'h0);

        // Overflow and reload
        wr(A_TH, 32'hFFFF_FFFC);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h3);
        rd_check("ovf_tl0", A_TL, 32'hFFFF_FFFE);
        cyc();
        rd_check("ovf_tl1", A_TL, 32'hFFFF_FFFF);
        check("ovf_irq_pre", {31'h0, oInterrupt}, 32'h0);
        cyc();
        rd_check("ovf_tl2",   A_TL,   32'hFFFF_FFFC);
        rd_check("ovf_tcon2", A_TCON, 32'h7);
        check("ovf_irq", {31'h0, oInterrupt}, 32'h1);

        // Clear status by software, counting continues
        wr(A_TCON, 32'h3);
        check("clr_irq", {31'h0, oInterrupt}, 32'h0);
        rd_check("clr_tcon", A_TCON, 32'h3);
        rd_check("clr_tl",   A_TL,   32'hFFFF_FFFD);
        cyc();
        rd_check("clr_tl_cnt", A_TL, 32'hFFFF_FFFE);
        cyc();
        rd_check("pre_race_tl", A_TL, 32'hFFFF_FFFF);

        // CPU write to TL on the overflow cycle wins
        wr(A_TL, 32'h0000_0010);
        rd_check("race_tl",   A_TL,   32'h0000_0010);
        rd_check("race_tcon", A_TCON, 32'h3);
        check("race_irq", {31'h0, oInterrupt}, 32'h0);
        cyc();
        rd_check("race_tl_cnt", A_TL, 32'h0000_0011);

        // TH write during reload: TL takes the old TH
        wr(A_TCON, 32'h0);
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TCON, 32'h3);
        wr(A_TH, 32'h0000_0100);
        rd_check("thrace_tl",   A_TL,   32'hFFFF_FFFC);
        rd_check("thrace_th",   A_TH,   32'h0000_0100);
        rd_check("thrace_tcon", A_TCON, 32'h7);
        wr(A_TCON, 32'h0);

        // Switch synchroniser
        iSwitch = 8'hA5;
        rd_check("sw_e0", A_SW, 32'h0);
        cyc();
        rd_check("sw_e1", A_SW, 32'h0);
        cyc();
        rd_check("sw_e2", A_SW, 32'h0000_00A5);
        cyc();
        rd_check("sw_e3", A_SW, 32'h0000_00A5);
        wr(A_SW, 32'h0000_0011);
        rd_check("sw_ro", A_SW, 32'h0000_00A5);

        // SYSTICK
        iMemAddr = A_TICK;
        iMemRead = 1'b1;
        #1;
        tick0 = oMemReadData;
        for (int i = 0; i < 10; i++) cyc();
        tick1 = oMemReadData;
        iMemRead = 1'b0;
`ifdef PERIPH_SYSTICK_EN
        check("tick_delta", tick1 - tick0, 32'd10);
        wr(A_TICK, 32'h0);
        iMemRead = 1'b1;
        #1;
        check("tick_ro", oMemReadData - tick1, 32'd1);
        iMemRead = 1'b0;
`else
        check("tick_off0", tick0, 32'h0);
        check("tick_off1", tick1, 32'h0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/periph_bus_timer.md
# periph_bus_timer

Memory-mapped peripheral block sitting directly downstream of the pipeline core's MEM stage. It consumes the core's data-memory request (address, read/write strobes, write data) for the peripheral address window. It returns read data combinationally within the same cycle and drives the core's level-sensitive interrupt input from a reloadable 32-bit timer. It also holds LED and 7-segment output registers and synchronises the switch inputs.

## Interface
Parameters:
- BASE_ADDR, 32'h40000000, base of the 32-byte peripheral window; decode on bits [31:5].

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, shared with the pipeline core
- reset  in  1  asynchronous, active-high reset
- iMemAddr  in  32  byte address from the core's MEM stage
- iMemRead  in  1  read strobe
- iMemWrite  in  1  write strobe
- iMemWriteData  in  32  write data
- oMemReadData  out  32  read data, combinational
- oInterrupt  out  1  timer interrupt, level, to the core
- iSwitch  in  8  asynchronous board switches
- oLed  out  8  LED register
- oDigi  out  12  7-segment register: [11:8] anode select, [7:0] segments

## Operation
- Window hit: iMemAddr[31:5] == BASE_ADDR[31:5].
- Offset: iMemAddr[4:2]; iMemAddr[1:0] ignored.
- Register map by word offset:
  - 0: TH, RW, reload value
  - 1: TL, RW, counter
  - 2: TCON, RW bits [2:0]: [0] enable, [1] irq enable, [2] irq status; upper bits read 0
  - 3: LED, RW [7:0]
  - 4: SWITCH, RO [7:0]
  - 5: DIGI, RW [11:0]
  - 6: SYSTICK, RO; see Configuration
  - 7: reserved, reads 0
- Reads: oMemReadData = selected register, zero-extended, when iMemRead && hit; otherwise 32'h0.
- Writes: iMemWrite && hit updates the register at the next rising clk edge. Writes to RO or reserved offsets are ignored.
- Timer, each cycle with TCON[0]=1:
  - if TL == 32'hFFFFFFFF: TL <= TH; TCON[2] <= 1 if TCON[1]
  - else TL <= TL+1
- TCON[0]=0: TL holds.
- TCON[2] is sticky; it is cleared only by a software write of 0 to that bit.
- oInterrupt = TCON[2] & TCON[1].
- Switches: two-flop synchroniser; the SWITCH register returns the second-stage value.
- Simultaneous CPU write and timer update to the same register (TL, or TCON status set): the CPU write wins entirely for that cycle.
- A CPU write to TH in the same cycle as a reload: TL loads the old TH.
- Both iMemRead and iMemWrite high: the read returns the pre-write value; the write commits at the edge.

## Timing
- Read latency: 0 cycles (combinational), valid within the core's MEM stage.
- Write latency: visible on read and outputs 1 cycle after the strobe edge.
- Overflow to interrupt: TL=FFFFFFFF at edge n gives TCON[2]=1 and oInterrupt=1 after edge n+1.
- Switch input to readable value: 2 clk edges.
- Reset, asynchronous, also mid-count: TH, TL, TCON, LED, DIGI, synchroniser and SYSTICK all 0.
  - oLed=8'h00, oDigi=12'h000, oInterrupt=0.
  - oMemReadData follows the combinational rule.

## Configuration
- PERIPH_SYSTICK_EN defined: offset 6 is a free-running 32-bit cycle counter.
  - Increments every clk and wraps FFFFFFFF to 0.
  - Reset to 0; not writable.
- Undefined: offset 6 reads 32'h0, and no counter flops are generated.

## Structure
- Shared package holds:
  - word-offset constants: OFF_TH, OFF_TL, OFF_TCON, OFF_LED, OFF_SWITCH, OFF_DIGI, OFF_SYSTICK
  - TCON bit indices: TCON_EN=0, TCON_IE=1, TCON_IS=2
- One sub-module, periph_timer: owns TH/TL/TCON, the reload logic and write arbitration. It takes decoded write enables and data and exports the three registers plus the irq.
- Top level owns decode, read mux, LED/DIGI registers, the synchroniser and SYSTICK.

## Test plan
- Reset mid-count with TCON=3 and TL=5: oInterrupt=0, oLed=0, oDigi=0, TL reads 0 after release.
- Write TH=FFFFFFFC, TL=FFFFFFFE, TCON=3:
  - TL reads FFFFFFFF after 1 cycle.
  - After 2 cycles TL=FFFFFFFC and TCON reads 7; oInterrupt=1.
- With TCON=7, write TCON=3: oInterrupt=0 next cycle; counting continues.
- At TL=FFFFFFFF, CPU writes TL=00000010 in the same cycle: TL reads 00000010 and TCON[2] stays 0.
- Drive iSwitch=A5: reading 40000010 returns 000000A5 from the 2nd edge onward. Reading 4000001C or 50000000 returns 0; writes there change nothing.
- PERIPH_SYSTICK_EN: two reads of 40000018 ten cycles apart differ by 10. Without the macro, the read returns 0.
